// File: rtl/ram_arbiter_if.sv
// Master-side bus bundle for one RAM requester: request payload, accept, read return.
interface ram_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              rstrb;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  // Requester view
  modport master (
    output addr, wdata, wmask, rstrb,
    input  ack, rdata, rvalid
  );

  // Arbiter view
  modport slave (
    input  addr, wdata, wmask, rstrb,
    output ack, rdata, rvalid
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle registered read.
// Grant is combinational from the current requests; read return is tagged to
// the master that issued it and qualified by that master's rvalid.
module ram_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  ram_arbiter_if.slave     m0,
  ram_arbiter_if.slave     m1,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  output logic             mem_rstrb,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned HOLD_W = 4;

  logic              req0;
  logic              req1;
  logic              contest;
  logic              gnt0;
  logic              gnt1;
  logic              last_grant;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rd_pend;
  logic              rd_owner;

  // Request decode and grant selection; nothing is granted while in reset
  always_comb begin
    req0    = m0.rstrb | (|m0.wmask);
    req1    = m1.rstrb | (|m1.wmask);
    contest = req0 & req1;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (resetn) begin
      if (contest) begin
        if (FIXED_PRIO != 0) begin
          if (hold_cnt == HOLD_W'(MAX_HOLD)) gnt1 = 1'b1;
          else                               gnt0 = 1'b1;
        end else begin
          if (last_grant) gnt0 = 1'b1;
          else            gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Steer the winner onto the RAM port; idle drives all zeros
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    if (gnt0) begin
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_wmask = m0.wmask;
      mem_rstrb = m0.rstrb;
    end else if (gnt1) begin
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_wmask = m1.wmask;
      mem_rstrb = m1.rstrb;
    end
  end

  // Accepts and read return; rvalid is masked during reset so an in-flight read is dropped
  always_comb begin
    m0.ack    = gnt0;
    m1.ack    = gnt1;
    m0.rdata  = mem_rdata;
    m1.rdata  = mem_rdata;
    m0.rvalid = resetn & rd_pend & ~rd_owner;
    m1.rvalid = resetn & rd_pend &  rd_owner;
  end

  // Arbitration history, read ownership and contention statistics
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant   <= 1'b1;
      hold_cnt     <= '0;
      rd_pend      <= 1'b0;
      rd_owner     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 | gnt1) last_grant <= gnt1;

      rd_pend <= mem_rstrb;
      if (mem_rstrb) rd_owner <= gnt1;

      if (FIXED_PRIO != 0) begin
        if (gnt1 || !req1)       hold_cnt <= '0;
        else if (contest && gnt0) hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end

      if (contest && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
